// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter with a 4-entry byte FIFO.
//
// A CPU store (EN) to address TX_ADDR pushes RegData into the FIFO. A
// start/data/stop serialiser drains the FIFO LSB first, 8N1 framing, one
// bit every CLKS_PER_BIT clocks. Frames for queued bytes follow each other
// with no idle gap.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous active-high reset (aborts frame, flushes FIFO)
//   EN       : store strobe, one cycle per store
//   Address  : store address; only TX_ADDR is decoded
//   RegData  : store data byte
//   TXD      : registered serial output, idle high
//   Busy     : frame in progress or FIFO non-empty
//   Full     : FIFO holds 4 bytes
//   Count    : FIFO occupancy, 0..4
//   Overflow : sticky, set when a store hits a full FIFO; cleared by rst only
module uart_tx_port #(
  parameter int         CLK_FREQ = 50000000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] TX_ADDR  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [7:0] Address,
  input  logic [7:0] RegData,
  output logic       TXD,
  output logic       Busy,
  output logic       Full,
  output logic [2:0] Count,
  output logic       Overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // A bit period shorter than two clocks cannot be timed by this counter.
  if (CLKS_PER_BIT < 2) begin : g_baud_check
    $error("uart_tx_port: CLK_FREQ/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       fifo_q [4];
  logic [7:0]       fifo_d [4];

  logic hit;
  logic push;
  logic drop;
  logic pop;
  logic bit_done;

  assign hit      = EN && (Address == TX_ADDR);
  // Fullness is judged on the registered count, so a pop on the same edge
  // does not make room for a store that arrives at a full FIFO.
  assign push     = hit && (count_q != 3'd4);
  assign drop     = hit && (count_q == 3'd4);
  assign bit_done = (baud_cnt_q == BIT_LAST);

  // Only the slot addressed by the write pointer takes the new byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
    assign fifo_d[gi] = (push && (wr_ptr_q == 2'(gi))) ? RegData : fifo_q[gi];
  end

  // Serialiser next-state. TXD is computed here and registered, so the line
  // changes on the same edge as the state it belongs to.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d      = 1'b1;
        baud_cnt_d = '0;
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end

      S_START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = S_DATA;
          txd_d      = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            // Shift right so the next bit to send is always in bit 0.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (count_q != 3'd0) begin
            // Chain straight into the next frame without an idle bit.
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
        txd_d      = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping. Pop only happens when count_q is non-zero, so the head
  // entry is always valid, and a simultaneous push and pop keeps the count.
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + 2'd1) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + 2'd1) : rd_ptr_q;
    overflow_d = overflow_q | drop;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      fifo_q     <= fifo_d;
    end
  end

  assign TXD      = txd_q;
  assign Busy     = (state_q != S_IDLE) || (count_q != 3'd0);
  assign Full     = (count_q == 3'd4);
  assign Count    = count_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed bench for uart_tx_port at CLK_FREQ=16, BAUD=1,
// i.e. 16 clocks per serial bit and 160 clocks per frame.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge; a store set up at one falling edge is captured by the next rising
// edge ("edge k"), and the sample at the following falling edge is "n_k".
module tb_uart_tx_port;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] Address = 8'h00;
  logic [7:0] RegData = 8'h00;
  logic       TXD;
  logic       Busy;
  logic       Full;
  logic [2:0] Count;
  logic       Overflow;

  int tests_run = 0;
  int tests_failed = 0;

  uart_tx_port #(
    .CLK_FREQ(16),
    .BAUD    (1),
    .TX_ADDR (8'hFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .EN      (EN),
    .Address (Address),
    .RegData (RegData),
    .TXD     (TXD),
    .Busy    (Busy),
    .Full    (Full),
    .Count   (Count),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  // Samples one frame, one sample per falling edge, starting at frame cycle
  // first_c (cycle 0 is the sample right after the start edge). Returns the
  // decoded byte and the number of samples that broke 8N1 framing or bit
  // stability. Ends on the last stop-bit sample.
  task automatic rx_frame(input int first_c, output logic [7:0] b, output int bad);
    logic bit_val;
    b = 8'h00;
    bad = 0;
    bit_val = 1'b0;
    for (int c = first_c; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c < CPB) begin
        if (TXD !== 1'b0) bad++;
      end else if (c >= 9 * CPB) begin
        if (TXD !== 1'b1) bad++;
      end else if (((c % CPB) == 0) || (c == first_c)) begin
        bit_val = TXD;
        b[3'((c / CPB) - 1)] = TXD;
      end else if (TXD !== bit_val) begin
        bad++;
      end
    end
    $display("[TB] rx frame byte=%02h bad_samples=%0d t=%0t", b, bad, $time);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    tests_run++; if (TXD !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b want 1", TXD); end
    tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", Busy); end
    tests_run++; if (Full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", Full); end
    tests_run++; if (Count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", Count); end
    tests_run++; if (Overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", Overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if ({TXD, Busy} !== 2'b10) begin tests_failed++; $display("FAIL reset_release: got TXD,Busy=%b want 10", {TXD, Busy}); end
  endtask

  task automatic test_single;
    logic [7:0] b;
    int bad;
    @(negedge clk);
    Address = 8'hFF; RegData = 8'hA5; EN = 1'b1;
    @(negedge clk);  // n_k
    EN = 1'b0;
    $display("[TB] write A5 t=%0t", $time);
    tests_run++; if (Count !== 3'd1) begin tests_failed++; $display("FAIL single_count_after_write: got %0d want 1", Count); end
    tests_run++; if ({TXD, Busy} !== 2'b11) begin tests_failed++; $display("FAIL single_idle_before_start: got TXD,Busy=%b want 11", {TXD, Busy}); end
    @(negedge clk);  // n_k+1: start bit must already be on the line
    tests_run++; if (TXD !== 1'b0) begin tests_failed++; $display("FAIL single_latency: got TXD=%b want 0", TXD); end
    tests_run++; if (Count !== 3'd0) begin tests_failed++; $display("FAIL single_pop: got %0d want 0", Count); end
    rx_frame(1, b, bad);
    tests_run++; if (b !== 8'hA5) begin tests_failed++; $display("FAIL single_byte: got %02h want a5", b); end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL single_framing: got %0d bad samples want 0", bad); end
    tests_run++; if (Busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_last_stop: got %b want 1", Busy); end
    @(negedge clk);  // 160 cycles after k+1
    tests_run++; if ({TXD, Busy} !== 2'b10) begin tests_failed++; $display("FAIL single_busy_fall: got TXD,Busy=%b want 10", {TXD, Busy}); end
  endtask

  task automatic test_ignore;
    int bad;
    bad = 0;
    @(negedge clk);
    Address = 8'hFE; RegData = 8'h55; EN = 1'b1;
    @(negedge clk);
    // Right address without the strobe must not store either.
    Address = 8'hFF; RegData = 8'h77; EN = 1'b0;
    $display("[TB] write 55 to FE t=%0t", $time);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((TXD !== 1'b1) || (Busy !== 1'b0) || (Count !== 3'd0)) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL ignore_activity: got %0d active cycles want 0", bad); end
    tests_run++; if ({Full, Overflow} !== 2'b00) begin tests_failed++; $display("FAIL ignore_flags: got Full,Overflow=%b want 00", {Full, Overflow}); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    int bad;
    int bad_sum;
    bad_sum = 0;
    @(negedge clk);
    Address = 8'hFF; RegData = 8'h11; EN = 1'b1;
    @(negedge clk);  // n_k
    RegData = 8'h22;
    tests_run++; if (Count !== 3'd1) begin tests_failed++; $display("FAIL b2b_count_k: got %0d want 1", Count); end
    @(negedge clk);  // n_k+1: push of 22 and pop of 11 on one edge
    RegData = 8'h33;
    tests_run++; if (Count !== 3'd1) begin tests_failed++; $display("FAIL b2b_count_k1: got %0d want 1", Count); end
    @(negedge clk);  // n_k+2
    EN = 1'b0;
    $display("[TB] write 11 22 33 t=%0t", $time);
    tests_run++; if (Count !== 3'd2) begin tests_failed++; $display("FAIL b2b_count_k2: got %0d want 2", Count); end
    rx_frame(2, b, bad);
    bad_sum += bad;
    tests_run++; if (b !== 8'h11) begin tests_failed++; $display("FAIL b2b_byte0: got %02h want 11", b); end
    tests_run++; if (Count !== 3'd2) begin tests_failed++; $display("FAIL b2b_count_end0: got %0d want 2", Count); end
    rx_frame(0, b, bad);
    bad_sum += bad;
    tests_run++; if (b !== 8'h22) begin tests_failed++; $display("FAIL b2b_byte1: got %02h want 22", b); end
    tests_run++; if (Count !== 3'd1) begin tests_failed++; $display("FAIL b2b_count_end1: got %0d want 1", Count); end
    rx_frame(0, b, bad);
    bad_sum += bad;
    tests_run++; if (b !== 8'h33) begin tests_failed++; $display("FAIL b2b_byte2: got %02h want 33", b); end
    tests_run++; if (bad_sum !== 0) begin tests_failed++; $display("FAIL b2b_framing_gap: got %0d bad samples want 0", bad_sum); end
    tests_run++; if ({Count, Busy} !== 4'b0001) begin tests_failed++; $display("FAIL b2b_last_stop: got Count=%0d Busy=%b want 0 1", Count, Busy); end
    @(negedge clk);
    tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_fall: got %b want 0", Busy); end
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    int bad;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      Address = 8'hFF; RegData = 8'(i + 1); EN = 1'b1;
      @(negedge clk);
    end
    EN = 1'b0;  // now at n_k+5, five samples into frame 1
    $display("[TB] write 01..06 t=%0t", $time);
    tests_run++; if (Count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d want 4", Count); end
    tests_run++; if (Full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full: got %b want 1", Full); end
    tests_run++; if (Overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", Overflow); end
    for (int j = 0; j < 5; j++) begin
      rx_frame((j == 0) ? 5 : 0, b, bad);
      tests_run++; if ((b !== 8'(j + 1)) || (bad !== 0)) begin tests_failed++; $display("FAIL ovf_frame%0d: got byte %02h bad %0d want %02h bad 0", j, b, bad, 8'(j + 1)); end
    end
    @(negedge clk);
    tests_run++; if ({Busy, Count, Full} !== 5'b0_000_0) begin tests_failed++; $display("FAIL ovf_drained: got Busy=%b Count=%0d Full=%b want 0 0 0", Busy, Count, Full); end
    tests_run++; if (Overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", Overflow); end
  endtask

  task automatic test_stop_collision;
    logic [7:0] b;
    int bad;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (Overflow !== 1'b0) begin tests_failed++; $display("FAIL coll_ovf_cleared: got %b want 0", Overflow); end
    for (int i = 0; i < 5; i++) begin
      Address = 8'hFF; RegData = 8'(8'hA1 + i); EN = 1'b1;
      @(negedge clk);
    end
    EN = 1'b0;  // n_k+4, four samples into frame 1
    $display("[TB] write A1..A5 t=%0t", $time);
    tests_run++; if ({Count, Full, Overflow} !== 5'b100_1_0) begin tests_failed++; $display("FAIL coll_fill: got Count=%0d Full=%b Ovf=%b want 4 1 0", Count, Full, Overflow); end
    rx_frame(4, b, bad);
    tests_run++; if ((b !== 8'hA1) || (bad !== 0)) begin tests_failed++; $display("FAIL coll_frame0: got byte %02h bad %0d want a1 bad 0", b, bad); end
    // This store lands on the edge that ends the stop bit and pops A2.
    Address = 8'hFF; RegData = 8'hEE; EN = 1'b1;
    @(negedge clk);
    EN = 1'b0;
    $display("[TB] write EE at stop end t=%0t", $time);
    tests_run++; if (Count !== 3'd3) begin tests_failed++; $display("FAIL coll_count: got %0d want 3", Count); end
    tests_run++; if (Overflow !== 1'b1) begin tests_failed++; $display("FAIL coll_overflow: got %b want 1", Overflow); end
    tests_run++; if (TXD !== 1'b0) begin tests_failed++; $display("FAIL coll_no_gap: got TXD=%b want 0", TXD); end
    for (int j = 0; j < 4; j++) begin
      rx_frame((j == 0) ? 1 : 0, b, bad);
      tests_run++; if ((b !== 8'(8'hA2 + j)) || (bad !== 0)) begin tests_failed++; $display("FAIL coll_frame%0d: got byte %02h bad %0d want %02h bad 0", j + 1, b, bad, 8'(8'hA2 + j)); end
    end
    @(negedge clk);
    tests_run++; if ({Busy, Count} !== 4'b0_000) begin tests_failed++; $display("FAIL coll_dropped_not_sent: got Busy=%b Count=%0d want 0 0", Busy, Count); end
  endtask

  task automatic test_reset_midframe;
    int bad;
    bad = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      Address = 8'hFF; RegData = (i == 0) ? 8'h00 : ((i == 1) ? 8'h81 : 8'h42); EN = 1'b1;
      @(negedge clk);
    end
    EN = 1'b0;  // n_k+2
    $display("[TB] write 00 81 42 t=%0t", $time);
    repeat (48) @(negedge clk);  // n_k+50: frame cycle 49, data bit 2 of 0x00
    tests_run++; if ({TXD, Count} !== 4'b0_010) begin tests_failed++; $display("FAIL midrst_pre: got TXD=%b Count=%0d want 0 2", TXD, Count); end
    #2 rst = 1'b1;
    #1;  // still before the next rising edge
    tests_run++; if ({TXD, Count, Busy, Full} !== 6'b1_000_0_0) begin tests_failed++; $display("FAIL midrst_async: got TXD=%b Count=%0d Busy=%b Full=%b want 1 0 0 0", TXD, Count, Busy, Full); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((TXD !== 1'b1) || (Busy !== 1'b0) || (Count !== 3'd0)) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL midrst_no_resume: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore();
    test_back_to_back();
    test_overflow();
    test_stop_collision();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
